// File: rtl/gpu_pkg.sv
`default_nettype none
// gpu_pkg: screen geometry, coordinate widths and rect_fill state encoding. Rev 1.0
// RECT_FILL_INVERT_EN adds the READ state used by read-modify-write fills.
package gpu_pkg;

  localparam int DEF_SCREEN_W = 320;
  localparam int DEF_SCREEN_H = 240;
  localparam int X_W          = 9;
  localparam int Y_W          = 8;

  typedef enum logic [1:0] {
    RF_IDLE   = 2'd0,
    RF_WRITE  = 2'd1,
    RF_FINISH = 2'd2
`ifdef RECT_FILL_INVERT_EN
    , RF_READ = 2'd3
`endif
  } rf_state_e;

endpackage
`default_nettype wire

// File: rtl/rect_walker.sv
`default_nettype none
// rect_walker: normalised/clipped rectangle bounds plus a row-major pixel cursor. Rev 1.0
module rect_walker
  import gpu_pkg::*;
#(
  parameter int SCREEN_W = DEF_SCREEN_W,
  parameter int SCREEN_H = DEF_SCREEN_H
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           load_i,
  input  logic           step_i,
  input  logic [X_W-1:0] x0_i,
  input  logic [X_W-1:0] x1_i,
  input  logic [Y_W-1:0] y0_i,
  input  logic [Y_W-1:0] y1_i,
  output logic [X_W-1:0] cur_x_o,
  output logic [Y_W-1:0] cur_y_o,
  output logic           last_o
);

  localparam logic [X_W-1:0] X_MAX = X_W'(SCREEN_W - 1);
  localparam logic [Y_W-1:0] Y_MAX = Y_W'(SCREEN_H - 1);

  logic [X_W-1:0] w_xl, w_xh, w_xl_c, w_xh_c;
  logic [Y_W-1:0] w_yl, w_yh, w_yl_c, w_yh_c;
  logic [X_W-1:0] xl_q, xl_d, xh_q, xh_d, x_q, x_d;
  logic [Y_W-1:0] yl_q, yl_d, yh_q, yh_d, y_q, y_d;

  assign w_xl   = (x0_i < x1_i) ? x0_i : x1_i;
  assign w_xh   = (x0_i < x1_i) ? x1_i : x0_i;
  assign w_yl   = (y0_i < y1_i) ? y0_i : y1_i;
  assign w_yh   = (y0_i < y1_i) ? y1_i : y0_i;
  assign w_xl_c = (w_xl > X_MAX) ? X_MAX : w_xl;
  assign w_xh_c = (w_xh > X_MAX) ? X_MAX : w_xh;
  assign w_yl_c = (w_yl > Y_MAX) ? Y_MAX : w_yl;
  assign w_yh_c = (w_yh > Y_MAX) ? Y_MAX : w_yh;

  always_comb begin
    xl_d = xl_q;
    xh_d = xh_q;
    yl_d = yl_q;
    yh_d = yh_q;
    x_d  = x_q;
    y_d  = y_q;
    if (load_i) begin
      xl_d = w_xl_c;
      xh_d = w_xh_c;
      yl_d = w_yl_c;
      yh_d = w_yh_c;
      x_d  = w_xl_c;
      y_d  = w_yl_c;
    end else if (step_i) begin
      // The caller never steps past the last pixel, so y cannot run beyond yh.
      if (x_q == xh_q) begin
        x_d = xl_q;
        y_d = y_q + 1'b1;
      end else begin
        x_d = x_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      xl_q <= '0;
      xh_q <= '0;
      yl_q <= '0;
      yh_q <= '0;
      x_q  <= '0;
      y_q  <= '0;
    end else begin
      xl_q <= xl_d;
      xh_q <= xh_d;
      yl_q <= yl_d;
      yh_q <= yh_d;
      x_q  <= x_d;
      y_q  <= y_d;
    end
  end

  assign cur_x_o = x_q;
  assign cur_y_o = y_q;
  assign last_o  = (x_q == xh_q) && (y_q == yh_q);

endmodule
`default_nettype wire

// File: rtl/rect_fill.sv
`default_nettype none
// rect_fill: walks a rectangle row-major and issues per-pixel framebuffer port-B writes. Rev 1.0
// Optional invert (read-modify-write) mode is compiled in with RECT_FILL_INVERT_EN.
module rect_fill
  import gpu_pkg::*;
#(
  parameter int SCREEN_W = DEF_SCREEN_W,
  parameter int SCREEN_H = DEF_SCREEN_H
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [X_W-1:0] x0,
  input  logic [X_W-1:0] x1,
  input  logic [Y_W-1:0] y0,
  input  logic [Y_W-1:0] y1,
  input  logic           color,
`ifdef RECT_FILL_INVERT_EN
  input  logic           invert,
`endif
  input  logic           abort,
  output logic           busy,
  output logic           done,
  output logic [X_W-1:0] x_b,
  output logic [Y_W-1:0] y_b,
  output logic           read_b,
  output logic           write_b,
  output logic           in_b,
  input  logic           out_b,
  input  logic           rdy_b
);

  rf_state_e state_q, state_d;
  logic      busy_q, busy_d;
  logic      done_q, done_d;
  logic      wr_q, wr_d;
  logic      inb_q, inb_d;
  logic      w_load, w_step, w_last;
`ifdef RECT_FILL_INVERT_EN
  logic      rd_q, rd_d;
  logic      inv_q, inv_d;
`endif

  rect_walker #(
    .SCREEN_W (SCREEN_W),
    .SCREEN_H (SCREEN_H)
  ) u_walker (
    .clk     (clk),
    .rst     (rst),
    .load_i  (w_load),
    .step_i  (w_step),
    .x0_i    (x0),
    .x1_i    (x1),
    .y0_i    (y0),
    .y1_i    (y1),
    .cur_x_o (x_b),
    .cur_y_o (y_b),
    .last_o  (w_last)
  );

  always_comb begin
    state_d = state_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    wr_d    = wr_q;
    inb_d   = inb_q;
    w_load  = 1'b0;
    w_step  = 1'b0;
`ifdef RECT_FILL_INVERT_EN
    rd_d    = rd_q;
    inv_d   = inv_q;
`endif
    case (state_q)
      RF_IDLE: begin
        if (start) begin
          w_load = 1'b1;
          busy_d = 1'b1;
`ifdef RECT_FILL_INVERT_EN
          inv_d  = invert;
          if (invert) begin
            state_d = RF_READ;
            rd_d    = 1'b1;
          end else begin
            state_d = RF_WRITE;
            wr_d    = 1'b1;
            inb_d   = color;
          end
`else
          state_d = RF_WRITE;
          wr_d    = 1'b1;
          inb_d   = color;
`endif
        end
      end
      RF_WRITE: begin
        if (rdy_b) begin
          if (w_last || abort) begin
            state_d = RF_FINISH;
            wr_d    = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            w_step = 1'b1;
`ifdef RECT_FILL_INVERT_EN
            if (inv_q) begin
              state_d = RF_READ;
              wr_d    = 1'b0;
              rd_d    = 1'b1;
            end
`endif
          end
        end
      end
`ifdef RECT_FILL_INVERT_EN
      // Abort is deliberately not checked here: a read is always followed by its write.
      RF_READ: begin
        if (rdy_b) begin
          state_d = RF_WRITE;
          rd_d    = 1'b0;
          wr_d    = 1'b1;
          inb_d   = ~out_b;
        end
      end
`endif
      RF_FINISH: begin
        state_d = RF_IDLE;
      end
      default: begin
        state_d = RF_IDLE;
        busy_d  = 1'b0;
        wr_d    = 1'b0;
`ifdef RECT_FILL_INVERT_EN
        rd_d    = 1'b0;
`endif
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RF_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      wr_q    <= 1'b0;
      inb_q   <= 1'b0;
`ifdef RECT_FILL_INVERT_EN
      rd_q    <= 1'b0;
      inv_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      wr_q    <= wr_d;
      inb_q   <= inb_d;
`ifdef RECT_FILL_INVERT_EN
      rd_q    <= rd_d;
      inv_q   <= inv_d;
`endif
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign write_b = wr_q;
  assign in_b    = inb_q;
`ifdef RECT_FILL_INVERT_EN
  assign read_b  = rd_q;
`else
  logic unused_out_b;
  assign unused_out_b = out_b;
  assign read_b       = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rect_fill.sv
`default_nettype none
// tb_rect_fill: table-driven, hand-sequenced and randomized checks of rect_fill
// against a row-major rectangle model and a behavioural port-B RAM.
module tb_rect_fill;

  localparam int W = 320;
  localparam int H = 240;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       color = 1'b0;
  logic       abort = 1'b0;
  logic [8:0] x0 = '0, x1 = '0;
  logic [7:0] y0 = '0, y1 = '0;
`ifdef RECT_FILL_INVERT_EN
  logic       invert = 1'b0;
`endif
  logic       busy, done, read_b, write_b, in_b, out_b, rdy_b;
  logic [8:0] x_b;
  logic [7:0] y_b;

  always #5 clk = ~clk;

  rect_fill dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .x0      (x0),
    .x1      (x1),
    .y0      (y0),
    .y1      (y1),
    .color   (color),
`ifdef RECT_FILL_INVERT_EN
    .invert  (invert),
`endif
    .abort   (abort),
    .busy    (busy),
    .done    (done),
    .x_b     (x_b),
    .y_b     (y_b),
    .read_b  (read_b),
    .write_b (write_b),
    .in_b    (in_b),
    .out_b   (out_b),
    .rdy_b   (rdy_b)
  );

  int n_cmp = 0;
  int n_bad = 0;

  function automatic bit chk(string nm, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      return 1'b0;
    end
    return 1'b1;
  endfunction

  // ---------------- behavioural RAM and access monitor ----------------
  typedef struct { int x; int y; int d; int cyc; bit wr; } acc_t;
  acc_t acc_q[$];
  int   dones[$];
  int   cyc = 0;
  int   hold_bad = 0, both_bad = 0, dbusy_bad = 0;
  logic mem [0:H-1][0:W-1];
  logic rdy_rand = 1'b1;
  bit   rand_rdy = 1'b0;
  bit   force_en = 1'b0;
  logic force_val = 1'b1;
  logic prev_stall = 1'b0;
  logic [8:0] px;
  logic [7:0] py;
  logic pd, pw;

  assign rdy_b = force_en ? force_val : rdy_rand;
  assign out_b = mem[y_b][x_b];

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    rdy_rand = rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
  end

  always @(negedge clk) begin
    if (rst) begin
      if (prev_stall &&
          !(x_b == px && y_b == py && write_b == pw && read_b == !pw && (!pw || in_b == pd)))
        hold_bad++;
      if (read_b && write_b) both_bad++;
      if ((write_b || read_b) && rdy_b) begin
        acc_q.push_back('{int'(x_b), int'(y_b), int'(in_b), cyc, write_b});
        if (write_b) mem[y_b][x_b] = in_b;
      end
      if (done) begin
        dones.push_back(cyc);
        if (busy) dbusy_bad++;
      end
      prev_stall = (write_b || read_b) && !rdy_b;
      px = x_b; py = y_b; pd = in_b; pw = write_b;
    end else begin
      prev_stall = 1'b0;
    end
  end

  // ---------------- stimulus helpers ----------------
  int s_cyc, busy_s, req_s;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic kick(int ax0, int ax1, int ay0, int ay1, bit col, bit inv);
    acc_q.delete();
    dones.delete();
    hold_bad = 0; both_bad = 0; dbusy_bad = 0;
    x0 = 9'(ax0); x1 = 9'(ax1); y0 = 8'(ay0); y1 = 8'(ay1);
    color = col;
`ifdef RECT_FILL_INVERT_EN
    invert = inv;
`else
    if (inv) $display("note: invert requested in a set-only build");
`endif
    start = 1'b1;
    step();
    start = 1'b0;
    s_cyc  = cyc;
    busy_s = int'(busy);
    req_s  = int'(write_b | read_b);
  endtask

  task automatic wait_done(int budget, bit glitch);
    int i = 0;
    while (dones.size() == 0 && i < budget) begin
      if (glitch && i == 3 && busy) begin
        start = 1'b1;
        x0 = 9'($urandom_range(0, 511)); y0 = 8'($urandom_range(0, 255));
      end
      step();
      start = 1'b0;
      i++;
    end
    if (dones.size() == 0) void'(chk("done timeout", 0, 1));
    repeat (3) step();
  endtask

  function automatic int clipc(int a, int lim);
    return (a > lim) ? lim : a;
  endfunction

  // Reference: normalise, clip, then enumerate pixels row-major.
  task automatic verify(string tag, int ax0, int ax1, int ay0, int ay1, bit col, bit zw);
    int   xl, xh, yl, yh, n, k;
    bit   ok;
    acc_t w[$];
    xl = clipc((ax0 < ax1) ? ax0 : ax1, W - 1);
    xh = clipc((ax0 < ax1) ? ax1 : ax0, W - 1);
    yl = clipc((ay0 < ay1) ? ay0 : ay1, H - 1);
    yh = clipc((ay0 < ay1) ? ay1 : ay0, H - 1);
    n  = (xh - xl + 1) * (yh - yl + 1);
    foreach (acc_q[i]) if (acc_q[i].wr) w.push_back(acc_q[i]);
    void'(chk({tag, " busy after start"}, busy_s, 1));
    void'(chk({tag, " request after start"}, req_s, 1));
    void'(chk({tag, " write count"}, w.size(), n));
    k  = 0;
    ok = 1'b1;
    for (int y = yl; y <= yh; y++) begin
      for (int x = xl; x <= xh; x++) begin
        if (ok && k < w.size()) begin
          ok = chk($sformatf("%s px%0d x", tag, k), w[k].x, x);
          ok = ok && chk($sformatf("%s px%0d y", tag, k), w[k].y, y);
          ok = ok && chk($sformatf("%s px%0d data", tag, k), w[k].d, int'(col));
          if (zw) ok = ok && chk($sformatf("%s px%0d cycle", tag, k), w[k].cyc, s_cyc + k);
        end
        k++;
      end
    end
    void'(chk({tag, " done pulses"}, dones.size(), 1));
    if (zw && dones.size() > 0) void'(chk({tag, " done cycle"}, dones[0], s_cyc + n));
    void'(chk({tag, " held while stalled"}, hold_bad, 0));
    void'(chk({tag, " read+write overlap"}, both_bad, 0));
    void'(chk({tag, " busy during done"}, dbusy_bad, 0));
  endtask

  // ---------------- test vectors ----------------
  typedef struct { int x0; int x1; int y0; int y1; bit col; int n; int fx; int fy; int lx; int ly; } vec_t;
  vec_t tbl [6];

  initial begin
    automatic acc_t wl[$];
    automatic int ax0, ax1, ay0, ay1;
    automatic bit col, edge_case;

    tbl[0] = '{2,   4,   1,   2,   1'b1, 6,   2,   1,   4,   2};
    tbl[1] = '{325, 318, 239, 239, 1'b0, 2,   318, 239, 319, 239};
    tbl[2] = '{5,   5,   7,   7,   1'b1, 1,   5,   7,   5,   7};
    tbl[3] = '{10,  0,   3,   0,   1'b0, 44,  0,   0,   10,  3};
    tbl[4] = '{319, 319, 0,   250, 1'b1, 240, 319, 0,   319, 239};
    tbl[5] = '{400, 500, 250, 245, 1'b0, 1,   319, 239, 319, 239};

    #1 rst = 1'b0;
    #3;
    void'(chk("reset busy", int'(busy), 0));
    void'(chk("reset done", int'(done), 0));
    void'(chk("reset write_b", int'(write_b), 0));
    void'(chk("reset read_b", int'(read_b), 0));
    void'(chk("reset in_b", int'(in_b), 0));
    void'(chk("reset x_b", int'(x_b), 0));
    void'(chk("reset y_b", int'(y_b), 0));
    step();
    rst = 1'b1;
    step();

    // Zero-wait table: contents, ordering, cycle-exact timing.
    for (int t = 0; t < 6; t++) begin
      kick(tbl[t].x0, tbl[t].x1, tbl[t].y0, tbl[t].y1, tbl[t].col, 1'b0);
      wait_done(4 * tbl[t].n + 40, 1'b0);
      wl.delete();
      foreach (acc_q[i]) if (acc_q[i].wr) wl.push_back(acc_q[i]);
      void'(chk($sformatf("tbl%0d count", t), wl.size(), tbl[t].n));
      if (wl.size() > 0) begin
        void'(chk($sformatf("tbl%0d first x", t), wl[0].x, tbl[t].fx));
        void'(chk($sformatf("tbl%0d first y", t), wl[0].y, tbl[t].fy));
        void'(chk($sformatf("tbl%0d last x", t), wl[wl.size()-1].x, tbl[t].lx));
        void'(chk($sformatf("tbl%0d last y", t), wl[wl.size()-1].y, tbl[t].ly));
      end
      verify($sformatf("tbl%0d", t), tbl[t].x0, tbl[t].x1, tbl[t].y0, tbl[t].y1, tbl[t].col, 1'b1);
    end

    // Stall on the second pixel for three cycles.
    force_en = 1'b1; force_val = 1'b1;
    kick(2, 4, 1, 2, 1'b1, 1'b0);
    step();
    force_val = 1'b0;
    for (int i = 0; i < 3; i++) begin
      void'(chk($sformatf("stall%0d x_b", i), int'(x_b), 3));
      void'(chk($sformatf("stall%0d y_b", i), int'(y_b), 1));
      void'(chk($sformatf("stall%0d write_b", i), int'(write_b), 1));
      void'(chk($sformatf("stall%0d in_b", i), int'(in_b), 1));
      if (i < 2) step();
    end
    step();
    force_val = 1'b1;
    wait_done(60, 1'b0);
    verify("stall", 2, 4, 1, 2, 1'b1, 1'b0);

    // Abort during the 4th write of a 10x10 fill while the RAM is stalled.
    kick(0, 9, 0, 9, 1'b1, 1'b0);
    repeat (3) step();
    force_val = 1'b0;
    abort = 1'b1;
    repeat (2) step();
    force_val = 1'b1;
    wait_done(40, 1'b0);
    abort = 1'b0;
    wl.delete();
    foreach (acc_q[i]) if (acc_q[i].wr) wl.push_back(acc_q[i]);
    void'(chk("abort write count", wl.size(), 4));
    if (wl.size() > 0) void'(chk("abort last x", wl[wl.size()-1].x, 3));
    void'(chk("abort done pulses", dones.size(), 1));
    void'(chk("abort idle write_b", int'(write_b), 0));
    void'(chk("abort idle busy", int'(busy), 0));

    // Asynchronous reset in the middle of a fill.
    force_en = 1'b0;
    kick(0, 50, 0, 10, 1'b1, 1'b0);
    repeat (5) step();
    #2 rst = 1'b0;
    #1;
    void'(chk("midrst busy", int'(busy), 0));
    void'(chk("midrst write_b", int'(write_b), 0));
    void'(chk("midrst read_b", int'(read_b), 0));
    void'(chk("midrst in_b", int'(in_b), 0));
    void'(chk("midrst x_b", int'(x_b), 0));
    void'(chk("midrst y_b", int'(y_b), 0));
    void'(chk("midrst done", int'(done), 0));
    repeat (2) step();
    rst = 1'b1;
    repeat (3) step();
    void'(chk("midrst no done pulse", dones.size(), 0));
    kick(tbl[0].x0, tbl[0].x1, tbl[0].y0, tbl[0].y1, tbl[0].col, 1'b0);
    wait_done(64, 1'b0);
    verify("after reset", tbl[0].x0, tbl[0].x1, tbl[0].y0, tbl[0].y1, tbl[0].col, 1'b1);

`ifdef RECT_FILL_INVERT_EN
    // Invert: alternating preset pixels, 4x1 read-modify-write.
    for (int x = 0; x < 4; x++) mem[0][x] = (x % 2 == 0);
    kick(0, 3, 0, 0, 1'b0, 1'b1);
    wait_done(60, 1'b0);
    invert = 1'b0;
    void'(chk("inv access count", acc_q.size(), 8));
    foreach (acc_q[i]) void'(chk($sformatf("inv acc%0d is write", i), int'(acc_q[i].wr), i % 2));
    for (int x = 0; x < 4; x++) void'(chk($sformatf("inv pixel%0d", x), int'(mem[0][x]), (x % 2 == 0) ? 0 : 1));
    if (dones.size() > 0) void'(chk("inv done cycle", dones[0], s_cyc + 8));
`endif

    // Randomized rectangles with random RAM wait states and ignored re-starts.
    rand_rdy = 1'b1;
    for (int r = 0; r < 25; r++) begin
      edge_case = ($urandom_range(0, 4) == 0);
      if (edge_case) begin
        ax0 = $urandom_range(300, 340); ax1 = $urandom_range(300, 340);
        ay0 = $urandom_range(225, 255); ay1 = $urandom_range(225, 255);
      end else begin
        ax0 = $urandom_range(0, 25); ax1 = $urandom_range(0, 25);
        ay0 = $urandom_range(0, 20); ay1 = $urandom_range(0, 20);
      end
      col = 1'($urandom_range(0, 1));
      kick(ax0, ax1, ay0, ay1, col, 1'b0);
      wait_done(6 * 26 * 21 + 60, 1'b1);
      verify($sformatf("rand%0d", r), ax0, ax1, ay0, ay1, col, 1'b0);
    end
    rand_rdy = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
